mutex: RTL and testbench

- Registered sign classifier for a signed two's-complement input word.
- Drives two mutually exclusive flags: strictly positive and strictly negative.
- Zero raises neither flag.
- Used as a small datapath qualifier; downstream logic treats the two flags as a one-hot-or-none pair.

---
 rtl/mutex.sv | 46 ++++
 tb/tb_mutex.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mutex.sv
// Registered sign classifier: flags a signed input word as
// strictly positive, strictly negative, or neither (zero).
`timescale 1ns/1ps
module mutex #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic             positive_flag,
  output logic             negative_flag
);

  logic sign;
  logic nonzero;

  logic pos_d;
  logic neg_d;
  logic pos_q;
  logic neg_q;

  assign sign    = in[WIDTH-1];
  assign nonzero = |in;

  // Sign bit alone decides negative; positive needs a clear
  // sign bit and at least one set magnitude bit, so the pair
  // can never be 1 together.
  always_comb begin
    neg_d = sign;
    pos_d = ~sign & nonzero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      neg_q <= neg_d;
    end
  end

  assign positive_flag = pos_q;
  assign negative_flag = neg_q;

endmodule

// File: tb/tb_mutex.sv
// Directed and random checks of the registered sign classifier
// against a signed-arithmetic reference model.
`timescale 1ns/1ps
module tb_mutex;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in;
  logic         positive_flag;
  logic         negative_flag;

  int total;
  int bad;

  mutex #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (in),
    .positive_flag(positive_flag),
    .negative_flag(negative_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic obs,
                     input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b",
             tag, obs, exp);
    end
  endtask

  // Reference: interpret the word as a signed integer.
  task automatic chk_model(input string tag,
                           input logic [W-1:0] v);
    int sv;
    sv = int'($signed(v));
    chk({tag, ".pos"}, positive_flag, sv > 0);
    chk({tag, ".neg"}, negative_flag, sv < 0);
    chk({tag, ".excl"},
        positive_flag & negative_flag, 1'b0);
  endtask

  task automatic step(input string tag,
                      input logic [W-1:0] v);
    @(negedge clk);
    in = v;
    @(posedge clk);
    #1;
    chk_model(tag, v);
  endtask

  logic [W-1:0] seq [7];
  logic [W-1:0] edg [3];
  logic [W-1:0] r;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    in    = 16'd10;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.pos", positive_flag, 1'b0);
    chk("rst.neg", negative_flag, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.hold.pos", positive_flag, 1'b0);
    @(posedge clk);
    #1;
    chk("rel.pos", positive_flag, 1'b1);
    chk("rel.neg", negative_flag, 1'b0);

    seq[0] = 16'd10;
    seq[1] = 16'hFFFB;
    seq[2] = 16'd0;
    seq[3] = 16'd12345;
    seq[4] = 16'hCFC7;
    seq[5] = 16'h7FFF;
    seq[6] = 16'h8000;
    foreach (seq[i]) step($sformatf("seq%0d", i), seq[i]);

    // Flags must hold across an input change between edges.
    step("lat.a", 16'd10);
    @(negedge clk);
    in = 16'hFFFB;
    #1;
    chk("lat.hold.pos", positive_flag, 1'b1);
    chk("lat.hold.neg", negative_flag, 1'b0);
    @(posedge clk);
    #1;
    chk("lat.pos", positive_flag, 1'b0);
    chk("lat.neg", negative_flag, 1'b1);

    edg[0] = 16'd1;
    edg[1] = 16'hFFFF;
    edg[2] = 16'd0;
    foreach (edg[i]) step($sformatf("edge%0d", i), edg[i]);

    step("mid.pre", 16'd10);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid.rst.pos", positive_flag, 1'b0);
    chk("mid.rst.neg", negative_flag, 1'b0);
    in = 16'hFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid.rel.pos", positive_flag, 1'b0);
    chk("mid.rel.neg", negative_flag, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      r = W'($urandom);
      if ((i % 50) == 0) r = '0;
      step($sformatf("rnd%0d", i), r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
